logic_reduce_unit: RTL

LOGIC_REDUCE_UNIT -- requirements
Module: logic_reduce_unit

---
 rtl/logic_pkg.sv | 18 +
 rtl/logic_op_combine.sv | 24 ++
 rtl/logic_reduce_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// Shared encodings for the logic reduction datapath: operation select and
// control FSM states.
package logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/logic_op_combine.sv
// Purely combinational bitwise combine of two operands under an op_e select.
module logic_op_combine
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Folds a frame of operand beats into one result with a latched bitwise op,
// counting beats and flagging frames longer than MAX_BEATS.
module logic_reduce_unit
  import logic_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  op_e              comb_op;
  logic [WIDTH-1:0] comb_y;

  function automatic logic [WIDTH-1:0] finalize(input op_e o, input logic [WIDTH-1:0] a);
    return (o == OP_NAND) ? ~a : a;
  endfunction

  // NAND is folded as AND; the inversion is applied once when the frame closes.
  assign comb_op = (op_q == OP_NAND) ? OP_AND : op_q;

  logic_op_combine #(.WIDTH(WIDTH)) u_combine (
    .a  (acc_q),
    .b  (in_data),
    .op (comb_op),
    .y  (comb_y)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: if (accept) begin
        acc_d   = in_data;
        op_d    = op_e'(op);
        count_d = CNT_W'(1);
        ovf_d   = 1'b0;
        state_d = in_last ? DONE : ACCUM;
      end
      ACCUM: if (accept) begin
        if (count_q == MAX_CNT) begin
          ovf_d = 1'b1;
        end else begin
          acc_d   = comb_y;
          count_d = count_q + CNT_W'(1);
        end
        if (in_last) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are captured once on entry to DONE and held until the handshake.
    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
    if (state_d == DONE && state_q != DONE) begin
      out_data_d  = finalize(op_d, acc_d);
      out_beats_d = count_d;
      out_ovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;

endmodule
